// File: rtl/cfg_mac_pe.sv
// Systolic-array processing element: signed MAC with selectable dataflow
// (output-, weight- or input-stationary), configurable multiplier pipeline,
// saturating accumulator, OS drain state machine and stuck-at fault injection.
module cfg_mac_pe #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int MUL_PIPE = 1,
  parameter int SATURATE = 1,
  parameter int FI_EN    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              load_stat,
  input  logic              drain,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] left_in,
  input  logic [ACC_W-1:0]  top_in,
  input  logic [1:0]        fi,
  output logic [DATA_W-1:0] right_out,
  output logic              right_valid,
  output logic [ACC_W-1:0]  bottom_out,
  output logic              bottom_valid,
  output logic              sat_flag,
  output logic              busy,
  output logic              err_drop
);

  typedef enum logic [1:0] {IDLE, COMPUTE, FLUSH, DRAIN} state_t;

  state_t              state, state_nx;
  logic [1:0]          mode_r;
  logic                ws_is;
  logic [DATA_W-1:0]   left_r, stat_reg;
  logic [ACC_W-1:0]    top_r;
  logic                vld_r;
  logic [ACC_W-1:0]    acc, ws_out;
  logic                ws_vld;

  logic signed [DATA_W-1:0]   op2;
  logic signed [2*DATA_W-1:0] mul;
  logic signed [ACC_W-1:0]    mul_ext;
  logic [ACC_W-1:0]           prod0;

  // pipe exit view: valid/product/psum leaving the multiplier stages
  logic             x_vld;
  logic [ACC_W-1:0] x_prod, x_psum;
  logic             pend;      // valid beats still upstream of the exit stage
  logic             pipe_any;  // any valid beat anywhere in input stage or pipe

  logic [ACC_W-1:0] add_a, sum_res;
  logic [ACC_W:0]   sum_ext;
  logic             sum_ovf;

  // WS and IS share the datapath; reserved mode 11 behaves as OS
  assign ws_is = (mode_r == 2'b01) || (mode_r == 2'b10);
  assign busy  = (state == FLUSH) || (state == DRAIN);

  // Input stage; beats arriving while busy are dropped and flagged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      left_r   <= '0;
      top_r    <= '0;
      vld_r    <= 1'b0;
      err_drop <= 1'b0;
    end else begin
      left_r   <= left_in;
      top_r    <= top_in;
      vld_r    <= valid_in & ~busy;
      err_drop <= valid_in & busy;
    end
  end

  assign right_out   = left_r;
  assign right_valid = vld_r;

  // Stationary operand and dataflow mode (mode only follows the port in IDLE)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_reg <= '0;
      mode_r   <= 2'b00;
    end else begin
      if (load_stat)      stat_reg <= top_in[DATA_W-1:0];
      if (state == IDLE)  mode_r   <= mode;
    end
  end

  assign op2     = ws_is ? $signed(stat_reg) : $signed(top_r[DATA_W-1:0]);
  assign mul     = $signed(left_r) * op2;
  assign mul_ext = ACC_W'(mul);

  // Fault injection overrides the product between multiplier and adder
  always_comb begin
    prod0 = mul_ext;
    if ((FI_EN != 0) && fi[0]) prod0 = fi[1] ? '1 : '0;
  end

  generate
    if (MUL_PIPE == 0) begin : g_comb
      assign x_vld    = vld_r;
      assign x_prod   = prod0;
      assign x_psum   = top_r;
      assign pend     = 1'b0;
      assign pipe_any = vld_r;
    end else begin : g_pipe
      logic [MUL_PIPE:0]              vld_pipe;
      logic [MUL_PIPE-1:0]            vld_q;
      logic [MUL_PIPE-1:0][ACC_W-1:0] prod_q, psum_q;

      assign vld_pipe = {vld_q, vld_r};

      // Multiplier register stages carrying product, valid and psum
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_q  <= '0;
          prod_q <= '0;
          psum_q <= '0;
        end else begin
          vld_q[0]  <= vld_r;
          prod_q[0] <= prod0;
          psum_q[0] <= top_r;
          for (int i = 1; i < MUL_PIPE; i++) begin
            vld_q[i]  <= vld_q[i-1];
            prod_q[i] <= prod_q[i-1];
            psum_q[i] <= psum_q[i-1];
          end
        end
      end

      assign x_vld    = vld_q[MUL_PIPE-1];
      assign x_prod   = prod_q[MUL_PIPE-1];
      assign x_psum   = psum_q[MUL_PIPE-1];
      assign pend     = |vld_pipe[MUL_PIPE-1:0];
      assign pipe_any = |vld_pipe;
    end
  endgenerate

  // One adder serves both the OS accumulator and the WS/IS psum path
  assign add_a   = ws_is ? x_psum : acc;
  assign sum_ext = {add_a[ACC_W-1], add_a} + {x_prod[ACC_W-1], x_prod};

  // Signed overflow detect and clamp
  always_comb begin
    sum_ovf = (SATURATE != 0) && (sum_ext[ACC_W] != sum_ext[ACC_W-1]);
    sum_res = sum_ext[ACC_W-1:0];
    if (sum_ovf) sum_res = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                          : {1'b0, {(ACC_W-1){1'b1}}};
  end

  // Accumulator, WS/IS result register and sticky saturation flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      ws_out   <= '0;
      ws_vld   <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      ws_vld <= x_vld & ws_is;
      if (x_vld && ws_is) ws_out <= sum_res;
      if (state == DRAIN) begin
        acc      <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (x_vld && !ws_is) acc      <= sum_res;
        if (x_vld && sum_ovf) sat_flag <= 1'b1;
      end
    end
  end

  // Bottom port: drained acc wins, else WS/IS result, else OS pass-through
  always_comb begin
    bottom_out   = ACC_W'($signed(top_r[DATA_W-1:0]));
    bottom_valid = vld_r;
    if (state == DRAIN) begin
      bottom_out   = acc;
      bottom_valid = 1'b1;
    end else if (ws_is) begin
      bottom_out   = ws_out;
      bottom_valid = ws_vld;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: drain only honoured in OS and when not already busy
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (drain && !ws_is) state_nx = FLUSH;
               else if (vld_r)      state_nx = COMPUTE;
      COMPUTE: if (drain && !ws_is) state_nx = FLUSH;
               else if (!pipe_any)  state_nx = IDLE;
      FLUSH:   if (!pend)           state_nx = DRAIN;
      DRAIN:                        state_nx = IDLE;
      default:                      state_nx = IDLE;
    endcase
  end

endmodule
